// File: rtl/ex_mem_skid.sv
// Two-entry skid-buffered EX/MEM pipeline register with valid/ready on both sides
// and a synchronous flush. Main register drives the memory-stage outputs directly.
module ex_mem_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_wd_o,
    output logic              mem_wreg_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [1:0]        occupancy_o
);

    // State encoding doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   acc;
    logic   out;

    assign in_entry    = '{wd: ex_wd_i, wreg: ex_wreg_i, wdata: ex_wdata_i};
    assign ex_ready_o  = !rst && (state != FULL);
    assign mem_valid_o = (state != EMPTY);
    assign acc         = ex_valid_i & ex_ready_o;
    assign out         = mem_valid_o & mem_ready_i;

    // Main is cleared whenever the buffer empties so a bubble presents all zeros.
    assign mem_wd_o    = main_q.wd;
    assign mem_wreg_o  = main_q.wreg;
    assign mem_wdata_o = main_q.wdata;
    assign occupancy_o = 2'(state);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state  <= ONE;
                        main_q <= in_entry;
                    end
                end
                ONE: begin
                    if (acc && !out) begin
                        state  <= FULL;
                        skid_q <= in_entry;
                    end else if (acc && out) begin
                        main_q <= in_entry;
                    end else if (out) begin
                        state  <= EMPTY;
                        main_q <= '0;
                    end
                end
                FULL: begin
                    if (out) begin
                        state  <= ONE;
                        main_q <= skid_q;
                        skid_q <= '0;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid.
module tb_ex_mem_skid;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  occupancy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [40:0] obs;
    logic [40:0] exp_v;

    ex_mem_skid #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
        .occupancy_o(occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [40:0] pk(input logic v, input logic [4:0] wd, input logic wreg,
                                       input logic [31:0] d, input logic [1:0] occ);
        return {v, wd, wreg, d, occ};
    endfunction

    function automatic logic [40:0] snap();
        return {mem_valid_o, mem_wd_o, mem_wreg_o, mem_wdata_o, occupancy_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] d);
        ex_valid_i = v;
        ex_wd_i    = wd;
        ex_wreg_i  = wreg;
        ex_wdata_i = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        offer(1'b1, 5'd3, 1'b1, 32'h1234_5678);
        mem_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            obs = snap();
            exp_v = pk(1'b0, 5'd0, 1'b0, 32'd0, 2'd0);
            n_cmp++;
            if (obs !== exp_v || ex_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold_%0d got=%h rdy=%b exp=%h rdy=0", c, obs, ex_ready_o, exp_v);
            end
        end
        rst = 1'b0;
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        #1;
        n_cmp++;
        if (ex_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready got=%b exp=1", ex_ready_o);
        end
        step();
        obs = snap();
        exp_v = pk(1'b0, 5'd0, 1'b0, 32'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_idle got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_streaming();
        mem_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, 5'(i), 1'b1, 32'(256 + i));
            #1;
            n_cmp++;
            if (ex_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready_%0d got=%b exp=1", i, ex_ready_o);
            end
            step();
            obs = snap();
            exp_v = pk(1'b1, 5'(i), 1'b1, 32'(256 + i), 2'd1);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL stream_%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        step();
        obs = snap();
        exp_v = pk(1'b0, 5'd0, 1'b0, 32'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL stream_drain got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_stall();
        logic [1:0] occ_exp [3];
        logic       rdy_exp [3];
        occ_exp = '{2'd1, 2'd2, 2'd2};
        rdy_exp = '{1'b1, 1'b0, 1'b0};
        mem_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            offer(1'b1, 5'(10 + c), 1'b1, 32'(32'hA0 + c));
            step();
            obs = snap();
            exp_v = pk(1'b1, 5'd10, 1'b1, 32'hA0, occ_exp[c]);
            n_cmp++;
            if (obs !== exp_v || ex_ready_o !== rdy_exp[c]) begin
                n_err++;
                $display("FAIL stall_%0d got=%h rdy=%b exp=%h rdy=%b", c, obs, ex_ready_o, exp_v, rdy_exp[c]);
            end
        end
        // Third entry (wd=12) is still being offered while the buffer drains.
        mem_ready_i = 1'b1;
        offer(1'b1, 5'd12, 1'b1, 32'hA2);
        step();
        obs = snap();
        exp_v = pk(1'b1, 5'd11, 1'b1, 32'hA1, 2'd1);
        n_cmp++;
        if (obs !== exp_v || ex_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release_b got=%h rdy=%b exp=%h rdy=1", obs, ex_ready_o, exp_v);
        end
        step();
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        obs = snap();
        exp_v = pk(1'b1, 5'd12, 1'b1, 32'hA2, 2'd1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL stall_release_c got=%h exp=%h", obs, exp_v);
        end
        step();
        obs = snap();
        exp_v = pk(1'b0, 5'd0, 1'b0, 32'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL stall_empty got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_flush();
        mem_ready_i = 1'b0;
        offer(1'b1, 5'd11, 1'b1, 32'hB1);
        step();
        offer(1'b1, 5'd12, 1'b1, 32'hB2);
        step();
        n_cmp++;
        if (occupancy_o !== 2'd2) begin
            n_err++;
            $display("FAIL flush_fill got=%0d exp=2", occupancy_o);
        end
        flush_i = 1'b1;
        offer(1'b1, 5'd9, 1'b1, 32'hDEAD);
        step();
        flush_i = 1'b0;
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        mem_ready_i = 1'b1;
        obs = snap();
        exp_v = pk(1'b0, 5'd0, 1'b0, 32'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v || ex_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_empty got=%h rdy=%b exp=%h rdy=1", obs, ex_ready_o, exp_v);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            obs = snap();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL flush_no_ghost_%0d got=%h exp=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_bubble();
        mem_ready_i = 1'b0;
        offer(1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF);
        step();
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        exp_v = pk(1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 2'd1);
        for (int c = 0; c < 2; c++) begin
            obs = snap();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL bubble_present_%0d got=%h exp=%h", c, obs, exp_v);
            end
            step();
        end
        mem_ready_i = 1'b1;
        step();
        obs = snap();
        exp_v = pk(1'b0, 5'd0, 1'b0, 32'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL bubble_idle got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        mem_ready_i = 1'b1;
        offer(1'b1, 5'd20, 1'b1, 32'hC0DE_0001);
        step();
        offer(1'b1, 5'd21, 1'b0, 32'hC0DE_0002);
        step();
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        obs = snap();
        exp_v = pk(1'b1, 5'd21, 1'b0, 32'hC0DE_0002, 2'd1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_one got=%h exp=%h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_reset_mid();
        mem_ready_i = 1'b0;
        offer(1'b1, 5'd7, 1'b1, 32'h77);
        step();
        offer(1'b1, 5'd8, 1'b1, 32'h88);
        step();
        rst = 1'b1;
        mem_ready_i = 1'b1;
        offer(1'b1, 5'd9, 1'b1, 32'h99);
        step();
        obs = snap();
        exp_v = pk(1'b0, 5'd0, 1'b0, 32'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v || ex_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got=%h rdy=%b exp=%h rdy=0", obs, ex_ready_o, exp_v);
        end
        rst = 1'b0;
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        step();
        obs = snap();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_mid_after got=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        mem_ready_i = 1'b0;
        offer(1'b0, 5'd0, 1'b0, 32'd0);
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubble();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
